// File: rtl/mio_pkg.sv
// mio_pkg: shared definitions for the MIO bus responder.
//   - address region codes decoded from Addr_out[31:28]
//   - responder FSM state encoding
//   - width of the wait-state counter (supports WAIT_CYCLES up to 15)
package mio_pkg;

  localparam logic [3:0] MIO_RAM = 4'h0;
  localparam logic [3:0] MIO_SW  = 4'hE;
  localparam logic [3:0] MIO_IO  = 4'hF;

  localparam int WAIT_CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mio_state_t;

  // Region code of a byte address.
  function automatic logic [3:0] region_of(input logic [31:0] addr);
    return addr[31:28];
  endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if: CPU <-> responder MIO bus bundle.
//   CPU_MIO   request strobe, held by the CPU until MIO_ready
//   MemRW     1 = write, 0 = read
//   Addr_out  byte address
//   Data_out  write data
//   wea       byte-lane write enables
//   Data_in   read data back to the CPU
//   MIO_ready one-cycle completion pulse
// Modports: master (CPU side), slave (responder side).
interface mio_bus_responder_if;
  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [3:0]  wea;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, Addr_out, Data_out, wea,
    input  Data_in, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, Addr_out, Data_out, wea,
    output Data_in, MIO_ready
  );
endinterface

// File: rtl/mio_ram.sv
// mio_ram: single-port synchronous RAM, 2^RAM_AW x 32 bits, with four
// byte-lane write enables and a registered read port.
//   clk    clock
//   we     byte-lane write enables (bit i -> wdata[8i+7:8i])
//   addr   word address
//   wdata  write data
//   rdata  read data, registered (valid the cycle after addr is presented)
// Contents are not reset. Each lane is its own byte-wide array so the
// tools can map it directly onto block RAM with per-byte enables.
module mio_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:(1<<RAM_AW)-1];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        rd_reg <= mem[addr];
      end

      assign rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: responder on the far side of the CPU's MIO bus.
// Decodes Addr_out[31:28] to a byte-writable RAM (0x0), a read-only switch
// port (0xE), the LED register (0xF, Addr_out[2]=0) and a free-running
// timer (0xF, Addr_out[2]=1). Completion is signalled by a one-cycle
// MIO_ready pulse after WAIT_CYCLES wait states.
//   clk, rst  clock, synchronous active-high reset
//   bus       MIO bus, slave side
//   sw        board switches
//   led       LED register
// Optional feature macro: MIO_TIMER_EN (timer present when defined;
// otherwise the timer address reads 0 and ignores writes).
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  mio_bus_responder_if.slave  bus,
  input  logic [15:0]         sw,
  output logic [15:0]         led
);

  localparam logic [WAIT_CW-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CW'(WAIT_CYCLES - 1);

  mio_state_t         state_reg, state_next;
  logic [WAIT_CW-1:0] cnt_reg, cnt_next;
  logic [31:0]        addr_reg, data_reg;
  logic [3:0]         wea_reg;
  logic               rw_reg;
  logic [31:0]        cur_addr;
  logic [31:0]        io_rdata, io_rdata_reg, ram_rdata, resp_data, data_hold_reg;
  logic [31:0]        timer_rd;
  logic [15:0]        led_reg;
  logic [3:0]         ram_we;
  logic               commit, io_hit;

  // While idle the request is still on the bus; afterwards use the latched
  // copy. This lets the RAM start its registered read on the request edge,
  // so the data is ready on entry to RESP even with zero wait states.
  assign cur_addr = (state_reg == IDLE) ? bus.Addr_out : addr_reg;

  // Address bits outside the decode are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr[27:3], cur_addr[1:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.CPU_MIO) begin
          cnt_next = CNT_LOAD;
          if (WAIT_CYCLES == 0) state_next = RESP;
          else                  state_next = WAIT;
        end
      end
      WAIT: begin
        if (!bus.CPU_MIO)      state_next = IDLE;  // abort, nothing committed
        else if (cnt_reg == 0) state_next = RESP;
        else                   cnt_next = cnt_reg - 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      wea_reg       <= '0;
      rw_reg        <= 1'b0;
      io_rdata_reg  <= '0;
      data_hold_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && bus.CPU_MIO) begin
        addr_reg <= bus.Addr_out;
        data_reg <= bus.Data_out;
        wea_reg  <= bus.wea;
        rw_reg   <= bus.MemRW;
      end
      // Non-RAM read data is sampled on the RESP-entry edge.
      if (state_next == RESP) io_rdata_reg <= io_rdata;
      if (state_reg == RESP)  data_hold_reg <= resp_data;
    end
  end

  always_comb begin
    io_rdata = '0;
    case (region_of(cur_addr))
      MIO_SW:  io_rdata = {16'h0, sw};
      MIO_IO:  io_rdata = cur_addr[2] ? timer_rd : {16'h0, led_reg};
      default: io_rdata = '0;
    endcase
  end

  assign resp_data     = (region_of(addr_reg) == MIO_RAM) ? ram_rdata : io_rdata_reg;
  assign bus.Data_in   = (state_reg == RESP) ? resp_data : data_hold_reg;
  assign bus.MIO_ready = (state_reg == RESP);

  assign commit = (state_reg == RESP) && rw_reg;
  assign io_hit = (region_of(addr_reg) == MIO_IO);

  // The RAM has no reset, so gate its enables with rst explicitly.
  assign ram_we = (commit && !rst && region_of(addr_reg) == MIO_RAM) ? wea_reg : 4'b0000;

  mio_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr[RAM_AW+1:2]),
    .wdata (data_reg),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= '0;
    end else if (commit && io_hit && !addr_reg[2]) begin
      if (wea_reg[0]) led_reg[7:0]  <= data_reg[7:0];
      if (wea_reg[1]) led_reg[15:8] <= data_reg[15:8];
    end
  end

  assign led = led_reg;

`ifdef MIO_TIMER_EN
  logic [31:0] timer_reg, timer_next;

  // Enabled lanes take the written bytes; lanes not written keep counting.
  always_comb begin
    timer_next = timer_reg + 32'd1;
    if (commit && io_hit && addr_reg[2]) begin
      for (int i = 0; i < 4; i++) begin
        if (wea_reg[i]) timer_next[8*i +: 8] = data_reg[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) timer_reg <= '0;
    else     timer_reg <= timer_next;
  end

  assign timer_rd = timer_reg;
`else
  assign timer_rd = '0;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed bench for mio_bus_responder.
// dut1 runs with WAIT_CYCLES = 1, dut3 with WAIT_CYCLES = 3 (abort cases).
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  logic [15:0] sw1, sw3, led1, led3;
  int          checks = 0;
  int          errors = 0;

  mio_bus_responder_if bus1();
  mio_bus_responder_if bus3();

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1), .sw (sw1), .led (led1)
  );

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(3)) dut3 (
    .clk (clk), .rst (rst3), .bus (bus3), .sw (sw3), .led (led3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  function automatic logic ready_of(input bit which);
    return which ? bus3.MIO_ready : bus1.MIO_ready;
  endfunction

  function automatic logic [31:0] data_of(input bit which);
    return which ? bus3.Data_in : bus1.Data_in;
  endfunction

  task automatic drive(input bit which, input logic req, input logic rw,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] wea);
    if (which) begin
      bus3.CPU_MIO = req; bus3.MemRW = rw; bus3.Addr_out = addr;
      bus3.Data_out = data; bus3.wea = wea;
    end else begin
      bus1.CPU_MIO = req; bus1.MemRW = rw; bus1.Addr_out = addr;
      bus1.Data_out = data; bus1.wea = wea;
    end
  endtask

  // One full handshake; also checks the request-edge-to-ready latency.
  task automatic xfer(input bit which, input string tag, input logic rw,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] wea, output logic [31:0] rdata);
    int lat;
    lat = 0;
    @(negedge clk);
    drive(which, 1'b1, rw, addr, data, wea);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready_of(which)) begin
        lat = i;
        break;
      end
    end
    rdata = data_of(which);
    check({tag, "_lat"}, 32'(lat), which ? 32'd4 : 32'd2);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic count_pulses(input bit which, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ready_of(which)) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          pulses;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sw1  = 16'h00FF;
    sw3  = 16'h0000;
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;

    check("rst_data_in", bus1.Data_in, 32'h0);
    check("rst_ready", {31'h0, bus1.MIO_ready}, 32'h0);
    check("rst_led", {16'h0, led1}, 32'h0);
    check("rst_ready3", {31'h0, bus3.MIO_ready}, 32'h0);

    xfer(1'b0, "rst_timer", 1'b0, 32'hF000_0004, 32'h0, 4'h0, rd);
    check("rst_timer_le8", {31'h0, rd <= 32'd8}, 32'h1);

    // RAM word write / read
    xfer(1'b0, "wr_word", 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, rd);
    xfer(1'b0, "rd_word", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("rd_word_data", rd, 32'h1234_5678);

    // Byte lane write
    xfer(1'b0, "wr_lane1", 1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, rd);
    xfer(1'b0, "rd_lane1", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("rd_lane1_data", rd, 32'h1234_AB78);

    // Write with no lanes enabled
    xfer(1'b0, "wr_wea0", 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, rd);
    xfer(1'b0, "rd_wea0", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("rd_wea0_data", rd, 32'h1234_AB78);
    @(posedge clk); #1;
    check("data_in_hold", bus1.Data_in, 32'h1234_AB78);

    // Upper address bits alias onto the same word
    xfer(1'b0, "rd_alias", 1'b0, 32'h0000_1010, 32'h0, 4'h0, rd);
    check("rd_alias_data", rd, 32'h1234_AB78);

    // LED register
    xfer(1'b0, "wr_led", 1'b1, 32'hF000_0000, 32'h0000_5A5A, 4'b0011, rd);
    @(posedge clk); #1;
    check("led_full", {16'h0, led1}, 32'h0000_5A5A);
    xfer(1'b0, "wr_led_lo", 1'b1, 32'hF000_0000, 32'hFFFF_FFC3, 4'b0001, rd);
    @(posedge clk); #1;
    check("led_lane0", {16'h0, led1}, 32'h0000_5AC3);

    // Switches and unmapped region
    xfer(1'b0, "rd_sw", 1'b0, 32'hE000_0000, 32'h0, 4'h0, rd);
    check("rd_sw_data", rd, 32'h0000_00FF);
    xfer(1'b0, "rd_unmapped", 1'b0, 32'h3000_0000, 32'h0, 4'h0, rd);
    check("rd_unmapped_data", rd, 32'h0);

    // Timer wrap
    xfer(1'b0, "wr_timer", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 4'b1111, rd);
    repeat (4) @(negedge clk);
    xfer(1'b0, "rd_timer", 1'b0, 32'hF000_0004, 32'h0, 4'h0, rd);
`ifdef MIO_TIMER_EN
    check("timer_wrapped", {31'h0, rd < 32'h10}, 32'h1);
`else
    check("timer_absent", rd, 32'h0);
`endif

    // WAIT_CYCLES = 3: baseline write, then aborted writes
    xfer(1'b1, "w3_wr", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111, rd);
    xfer(1'b1, "w3_rd", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("w3_rd_data", rd, 32'hCAFE_F00D);

    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    count_pulses(1'b1, 8, pulses);
    check("abort_no_ready", 32'(pulses), 32'd0);
    xfer(1'b1, "abort_rd", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("abort_rd_data", rd, 32'hCAFE_F00D);

    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h2222_2222, 4'b1111);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("rst_abort_ready", {31'h0, bus3.MIO_ready}, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    count_pulses(1'b1, 8, pulses);
    check("rst_abort_no_ready", 32'(pulses), 32'd0);
    xfer(1'b1, "rst_abort_rd", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("rst_abort_rd_data", rd, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO responder on the far side of the single-cycle CPU's MIO bus. Accepts CPU-issued requests (CPU_MIO, MemRW, Addr_out, Data_out, wea), decodes the address to a byte-writable data RAM, an LED register, a switch input port and an optional free-running timer. Returns read data on Data_in and signals completion on MIO_ready after a programmable number of wait states. Sits between the CPU top and the board peripherals in the SoC top.

## Interface
- RAM_AW, 10, RAM word-address width (RAM is 2^RAM_AW x 32 bits).
- WAIT_CYCLES, 1, wait states inserted before MIO_ready; range 0..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- CPU_MIO  in  1  request strobe; held high by the CPU until MIO_ready.
- MemRW  in  1  1 = write, 0 = read.
- Addr_out  in  32  byte address.
- Data_out  in  32  write data, byte lanes aligned to Addr_out[31:2].
- wea  in  4  byte-lane write enables, bit i = Data_out[8i+7:8i].
- sw  in  16  board switches.
- Data_in  out  32  read data to the CPU, valid while MIO_ready = 1.
- MIO_ready  out  1  one-cycle completion pulse.
- led  out  16  LED register.

## Operation
- Address map on Addr_out[31:28]:
  - 0x0: RAM, word index Addr_out[RAM_AW+1:2]; upper bits ignored (aliasing).
  - 0xE: switches, read-only; read returns {16'h0, sw}.
  - 0xF, Addr_out[2] = 0: LED register; only wea[1:0] lanes are used.
  - 0xF, Addr_out[2] = 1: timer.
  - Anything else: reads return 0, writes are ignored, the handshake still completes.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if CPU_MIO = 1, latch address, data, wea and MemRW. Go to WAIT with the counter at WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES = 0.
  - WAIT: decrement the counter; go to RESP at 0. If CPU_MIO drops, abort to IDLE with no side effects.
  - RESP: MIO_ready = 1. A write commits to the target on this edge, honouring wea. The read value was captured on the RESP-entry edge. Then go to IDLE unconditionally (one bubble cycle between transactions).
- Write with wea = 0: the handshake completes and no storage changes.
- Timer: a 32-bit counter that increments every cycle and wraps from 0xFFFF_FFFF to 0. A bus write loads the enabled lanes; when a write and the increment coincide, the write wins.

## Timing
- Reset values: Data_in = 0, MIO_ready = 0, led = 0, timer = 0, state = IDLE. RAM contents are not reset.
- Request sampled at edge N; MIO_ready is high during cycle N+WAIT_CYCLES+1.
- Minimum request-to-request spacing: WAIT_CYCLES+2 cycles.
- led and timer take their new value in the cycle after MIO_ready.
- rst during WAIT or RESP: the transaction is discarded, no write commits, and MIO_ready is 0 on the next cycle.
- Data_in holds its last value outside RESP.

## Configuration
- MIO_TIMER_EN defined: the timer is present as described above.
- MIO_TIMER_EN undefined: no counter logic; the timer address reads 0 and writes are ignored.

## Structure
- Package mio_pkg:
  - region constants (MIO_RAM = 4'h0, MIO_SW = 4'hE, MIO_IO = 4'hF);
  - FSM state enum;
  - WAIT counter width constant.
- Sub-module mio_ram: single-port synchronous RAM with 4 byte-lane write enables and registered read. Parameter RAM_AW.

## Test plan
- Reset: assert rst for 2 cycles. Data_in = 0, MIO_ready = 0, led = 0; a timer read immediately after reset returns a value ≤ 8.
- Word write/read (WAIT_CYCLES = 1): write 0x12345678 to 0x0000_0010 with wea = 4'b1111. MIO_ready rises exactly 2 cycles after the request edge. A read of 0x10 returns 0x12345678.
- Byte lane write: wea = 4'b0010, Data_out = 0x0000AB00 to 0x10. Readback = 0x1234AB78. A write with wea = 0 leaves the value unchanged.
- IO access:
  - write 0x0000_5A5A to 0xF000_0000, then led = 0x5A5A;
  - with sw = 0x00FF, a read of 0xE000_0000 returns 0x0000_00FF;
  - a read of 0x3000_0000 returns 0.
- Timer (MIO_TIMER_EN defined): write 0xFFFF_FFFE to 0xF000_0004, then read 5 cycles later. The result is less than 0x10, showing the wrap. With the macro undefined, the same read returns 0.
- Abort/reset: drop CPU_MIO during WAIT of a write to 0x10 (WAIT_CYCLES = 3). RAM is unchanged and MIO_ready never pulses. Repeat with rst asserted mid-WAIT instead: same result.
